// File: rtl/eth_pkt_rd_ctrl_if.sv
// Bus bundle between the packet FIFO read port, the UDP TX byte engine and eth_pkt_rd_ctrl.
// master = the read controller, slave = the FIFO/UDP side.
interface eth_pkt_rd_ctrl_if #(
  parameter int LVL_WIDTH = 11
);
  logic                 fifo_rd_en;
  logic [31:0]          fifo_rd_data;
  logic                 fifo_rd_empty;
  logic [LVL_WIDTH-1:0] fifo_rd_water_level;
  logic                 tx_start_en;
  logic [15:0]          tx_byte_num;
  logic                 tx_req;
  logic [7:0]           tx_data;
  logic                 tx_done;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_rd_empty,
    input  fifo_rd_water_level,
    output tx_start_en,
    output tx_byte_num,
    input  tx_req,
    output tx_data,
    input  tx_done
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_rd_empty,
    output fifo_rd_water_level,
    input  tx_start_en,
    input  tx_byte_num,
    output tx_req,
    input  tx_data,
    output tx_done
  );
endinterface

// File: rtl/eth_pkt_rd_ctrl.sv
// Packet FIFO read controller: waits for a full packet, then feeds UDP TX bytes with just-in-time pops.
// Optional ETH_PKT_RD_LSB_FIRST_EN sends byte [7:0] of each word first instead of [31:24].
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a full packet in the FIFO
// PREFETCH  | pop the first word
// LOAD      | capture first word, pulse tx_start_en
// SEND      | one byte per tx_req, pop next word on byte 2
// WAIT_DONE | all bytes handed over, waiting for tx_done
// GAP       | inter-packet idle count-down
module eth_pkt_rd_ctrl #(
  parameter int PKT_WORDS  = 256,
  parameter int LVL_WIDTH  = 11,
  parameter int GAP_CYCLES = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  eth_pkt_rd_ctrl_if.master     bus,
  output logic                  busy,
  output logic [15:0]           pkt_cnt,
  output logic                  err_underflow
);

  localparam int          WL_W     = 14;
  localparam logic [15:0] BYTE_NUM = 16'(PKT_WORDS * 4);
  localparam logic [15:0] LAST_CNT = 16'(PKT_WORDS * 4 - 1);
  localparam logic [WL_W-1:0] WL_INIT = WL_W'(PKT_WORDS - 1);
  localparam logic [15:0] GAP_INIT = 16'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_LOAD,
    S_SEND,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       cur_word_q, cur_word_d;
  logic [WL_W-1:0]   words_left_q, words_left_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [15:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic              err_underflow_q, err_underflow_d;
  logic [15:0]       gap_cnt_q, gap_cnt_d;

  logic [LVL_WIDTH-1:0] water_level;
  logic                 level_ok;
  logic [7:0]           sel_byte;
  logic                 fifo_rd_en_c;
  logic                 tx_start_c;

  assign water_level = bus.fifo_rd_water_level;
  assign level_ok    = (32'(water_level) >= 32'(PKT_WORDS));

  always_comb begin
    sel_byte = 8'h00;
    case (byte_idx_q)
`ifdef ETH_PKT_RD_LSB_FIRST_EN
      2'd0: sel_byte = cur_word_q[7:0];
      2'd1: sel_byte = cur_word_q[15:8];
      2'd2: sel_byte = cur_word_q[23:16];
      2'd3: sel_byte = cur_word_q[31:24];
`else
      2'd0: sel_byte = cur_word_q[31:24];
      2'd1: sel_byte = cur_word_q[23:16];
      2'd2: sel_byte = cur_word_q[15:8];
      2'd3: sel_byte = cur_word_q[7:0];
`endif
      default: sel_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    cur_word_d      = cur_word_q;
    words_left_d    = words_left_q;
    byte_idx_d      = byte_idx_q;
    byte_cnt_d      = byte_cnt_q;
    tx_data_d       = tx_data_q;
    pkt_cnt_d       = pkt_cnt_q;
    err_underflow_d = err_underflow_q;
    gap_cnt_d       = gap_cnt_q;
    fifo_rd_en_c    = 1'b0;
    tx_start_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (level_ok && !bus.fifo_rd_empty) state_d = S_PREFETCH;
      end
      S_PREFETCH: begin
        fifo_rd_en_c = 1'b1;
        state_d      = S_LOAD;
      end
      S_LOAD: begin
        cur_word_d   = bus.fifo_rd_data;
        words_left_d = WL_INIT;
        byte_idx_d   = 2'd0;
        byte_cnt_d   = 16'd0;
        tx_start_c   = 1'b1;
        state_d      = S_SEND;
      end
      S_SEND: begin
        if (bus.tx_req) begin
          tx_data_d  = sel_byte;
          byte_idx_d = byte_idx_q + 2'd1;
          byte_cnt_d = byte_cnt_q + 16'd1;
          // Pop on byte 2 so the next word is on the FIFO output by byte 3.
          if (byte_idx_q == 2'd2 && words_left_q != '0) begin
            words_left_d = words_left_q - 1'b1;
            if (bus.fifo_rd_empty) err_underflow_d = 1'b1;
            else                   fifo_rd_en_c    = 1'b1;
          end
          if (byte_idx_q == 2'd3) cur_word_d = bus.fifo_rd_data;
          if (byte_cnt_q == LAST_CNT) state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (bus.tx_done) begin
          pkt_cnt_d = pkt_cnt_q + 16'd1;
          gap_cnt_d = GAP_INIT;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 16'd0) state_d = S_IDLE;
        else                    gap_cnt_d = gap_cnt_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q         <= S_IDLE;
      cur_word_q      <= 32'h0;
      words_left_q    <= '0;
      byte_idx_q      <= 2'd0;
      byte_cnt_q      <= 16'd0;
      tx_data_q       <= 8'h00;
      pkt_cnt_q       <= 16'd0;
      err_underflow_q <= 1'b0;
      gap_cnt_q       <= 16'd0;
    end else begin
      state_q         <= state_d;
      cur_word_q      <= cur_word_d;
      words_left_q    <= words_left_d;
      byte_idx_q      <= byte_idx_d;
      byte_cnt_q      <= byte_cnt_d;
      tx_data_q       <= tx_data_d;
      pkt_cnt_q       <= pkt_cnt_d;
      err_underflow_q <= err_underflow_d;
      gap_cnt_q       <= gap_cnt_d;
    end
  end

  assign bus.fifo_rd_en  = fifo_rd_en_c;
  assign bus.tx_start_en = tx_start_c;
  assign bus.tx_byte_num = BYTE_NUM;
  assign bus.tx_data     = tx_data_q;
  assign busy            = (state_q != S_IDLE);
  assign pkt_cnt         = pkt_cnt_q;
  assign err_underflow   = err_underflow_q;

endmodule

// File: doc/eth_pkt_rd_ctrl.md
# eth_pkt_rd_ctrl

Read-side packet controller on the read port of the Ethernet packet FIFO. It waits until one full packet of 32-bit words is buffered, then starts a UDP transmit. It serializes the words into bytes on the UDP TX byte-request handshake and pops the FIFO just in time, so back-to-back byte requests see no bubble. It sits between the FIFO's read side and the UDP/GMII transmit engine, in the `rd_clk` domain.

## Interface
Parameters:
- `PKT_WORDS`, 256: 32-bit words per packet. Range 2..16383. Byte count is `PKT_WORDS*4`.
- `LVL_WIDTH`, 11: width of the FIFO read water level (FIFO depth width + 1).
- `GAP_CYCLES`, 16: idle cycles after `tx_done` before the next packet may start. Range 1..65535.

Ports:
- `rd_clk`  in  1  the single clock.
- `rd_rst_n`  in  1  asynchronous active-low reset.
- `fifo_rd_en`  out  1  FIFO pop, combinational.
- `fifo_rd_data`  in  32  FIFO output. Valid the cycle after a pop and held while `fifo_rd_en` is low.
- `fifo_rd_empty`  in  1  FIFO empty.
- `fifo_rd_water_level`  in  LVL_WIDTH  words stored in the FIFO.
- `tx_start_en`  out  1  one-cycle packet start pulse to UDP TX.
- `tx_byte_num`  out  16  payload length; constant `PKT_WORDS*4`.
- `tx_req`  in  1  UDP TX requests the next byte.
- `tx_data`  out  8  payload byte, registered.
- `tx_done`  in  1  UDP TX packet complete pulse.
- `busy`  out  1  high in every state except IDLE.
- `pkt_cnt`  out  16  packets completed; wraps at 16 bits.
- `err_underflow`  out  1  sticky; set when a pop is needed while the FIFO is empty.

## Operation
States and transitions:
- IDLE: move to PREFETCH when `fifo_rd_water_level >= PKT_WORDS` and `!fifo_rd_empty`.
- PREFETCH: one cycle; `fifo_rd_en=1`; then LOAD.
- LOAD: one cycle.
  - `cur_word <= fifo_rd_data`.
  - `words_left <= PKT_WORDS-1`, `byte_idx <= 0`, `byte_cnt <= 0`.
  - `tx_start_en=1`.
  - Then SEND.
- SEND: on each cycle with `tx_req=1`:
  - `tx_data <= cur_word` byte selected by `byte_idx`; byte 0 = [31:24] (MSB first).
  - `byte_idx` increments mod 4; `byte_cnt` increments.
  - When `byte_idx==2` and `words_left!=0`: `fifo_rd_en = tx_req & !fifo_rd_empty` (combinational) and `words_left` decrements.
  - When `byte_idx==3`: `cur_word <= fifo_rd_data`.
  - The request that makes `byte_cnt == PKT_WORDS*4` moves to WAIT_DONE.
- WAIT_DONE: on `tx_done`, increment `pkt_cnt` and load the gap counter with `GAP_CYCLES-1`; move to GAP.
- GAP: count down to 0, then IDLE.

Rules:
- `tx_req` outside SEND is ignored; `tx_data` holds its last value.
- `tx_done` outside WAIT_DONE is ignored.
- A byte-2 pop required while `fifo_rd_empty=1` gives no pop and sets `err_underflow`. The stale word is sent anyway and the FSM continues. The flag clears only on reset.
- Gaps in `tx_req` are allowed anywhere. The FIFO holds its output, so a word popped at byte 2 is still valid at byte 3 after any gap.
- Exactly `PKT_WORDS` pops occur per packet: 1 in PREFETCH and `PKT_WORDS-1` in SEND.

## Timing
- Reset (async assert, release on the `rd_clk` edge): state IDLE.
  - `fifo_rd_en=0`, `tx_start_en=0`, `tx_data=0`.
  - `busy=0`, `pkt_cnt=0`, `err_underflow=0`.
  - `tx_byte_num=PKT_WORDS*4` at all times.
- Start latency: level condition true at cycle N gives PREFETCH at N+1 and `tx_start_en` at N+2.
- Byte latency: `tx_req` sampled at edge E updates `tx_data` at E. This sustains one byte per cycle.
- Reset asserted mid-packet aborts immediately. Words already popped are lost and no `tx_done` is awaited.
- End-to-start spacing: at least `GAP_CYCLES`+2 cycles from `tx_done` to the next `tx_start_en`.

## Configuration
- `ETH_PKT_RD_LSB_FIRST_EN`:
  - Defined: byte 0 = `cur_word[7:0]` through byte 3 = [31:24].
  - Undefined: MSB first as described above.
  - Pop timing, counts and states are identical either way.

## Test plan
- `PKT_WORDS=4`, FIFO preloaded with 0x01020304..0x0D0E0F10, `tx_req` held high after start: `tx_start_en` pulses once; `tx_data` = 0x01..0x10 on 16 consecutive edges; exactly 4 pops; `tx_done` then `pkt_cnt=1`.
- Same stimulus with `ETH_PKT_RD_LSB_FIRST_EN` defined: `tx_data` sequence 04,03,02,01,08,...,0D.
- Water level = 3 with `PKT_WORDS=4`: remains IDLE, no pop, `busy=0`; raising the level to 4 gives `tx_start_en` 2 cycles later.
- `tx_req` with random 0-5 cycle gaps: byte sequence identical to the first test, no extra pops.
- FIFO forced empty before the 2nd word pop: `err_underflow=1`, packet still ends after 16 bytes; flag stays set until `rd_rst_n` asserts.
- `rd_rst_n` pulsed low after 5 bytes: all outputs return to reset values at once. With the FIFO refilled, the next packet starts cleanly with `pkt_cnt=0`.
